// File: rtl/pad_in_filter.sv
// Pad input conditioning: per-pad synchroniser, optional stable-time glitch filter,
// and single-cycle rise/fall event pulses on the conditioned value.
module pad_in_filter #(
    parameter int unsigned      NPads      = 59,
    parameter int unsigned      FilterCntW = 4,
    parameter int unsigned      SyncStages = 2,
    parameter logic [NPads-1:0] ResetVal   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NPads-1:0]      pad_in_i,
    input  logic [NPads-1:0]      filter_en_i,
    input  logic [FilterCntW-1:0] filter_thresh_i,
    output logic [NPads-1:0]      pad_in_o,
    output logic [NPads-1:0]      rise_o,
    output logic [NPads-1:0]      fall_o
);

    logic [NPads-1:0]      sync_q [SyncStages];
    logic [NPads-1:0]      s;
    logic [NPads-1:0]      cand_q, cand_d;
    logic [NPads-1:0]      filt_q, filt_d;
    logic [NPads-1:0]      rise_q, fall_q;
    logic [FilterCntW-1:0] cnt_q [NPads];
    logic [FilterCntW-1:0] cnt_d [NPads];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= ResetVal;
            end
        end else begin
            sync_q[0] <= pad_in_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SyncStages-1];

    always_comb begin
        cand_d = cand_q;
        filt_d = filt_q;
        for (int p = 0; p < NPads; p++) begin
            cnt_d[p] = cnt_q[p];
            // Any disagreement with the candidate restarts the stable-time count.
            if (s[p] != cand_q[p]) begin
                cand_d[p] = s[p];
                cnt_d[p]  = '0;
            end else if (cnt_q[p] != '1) begin
                cnt_d[p] = cnt_q[p] + FilterCntW'(1);
            end

            if (!filter_en_i[p]) begin
                filt_d[p] = s[p];
            end else if ((s[p] == cand_q[p]) && (cnt_q[p] >= filter_thresh_i)) begin
                filt_d[p] = cand_q[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q <= ResetVal;
            filt_q <= ResetVal;
            rise_q <= '0;
            fall_q <= '0;
            for (int p = 0; p < NPads; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            cand_q <= cand_d;
            filt_q <= filt_d;
            rise_q <= filt_d & ~filt_q;
            fall_q <= ~filt_d & filt_q;
            for (int p = 0; p < NPads; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    assign pad_in_o = filt_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: reset values, sync latency, glitch filtering,
// threshold/enable changes mid-count and asynchronous reset.
module tb_pad_in_filter;

    localparam int unsigned NPads      = 59;
    localparam int unsigned FilterCntW = 4;
    localparam logic [NPads-1:0] RstVal = NPads'(1) << 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NPads-1:0]      pad_in;
    logic [NPads-1:0]      filt_en;
    logic [FilterCntW-1:0] thresh;
    logic [NPads-1:0]      pad_out;
    logic [NPads-1:0]      rise;
    logic [NPads-1:0]      fall;

    int n_total = 0;
    int n_bad   = 0;

    pad_in_filter #(
        .NPads      (NPads),
        .FilterCntW (FilterCntW),
        .SyncStages (2),
        .ResetVal   (RstVal)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pad_in_i        (pad_in),
        .filter_en_i     (filt_en),
        .filter_thresh_i (thresh),
        .pad_in_o        (pad_out),
        .rise_o          (rise),
        .fall_o          (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rise_cnt, fall_cnt, rise_at, seen;

    initial begin
        rst_n   = 1'b0;
        pad_in  = '0;
        filt_en = '0;
        thresh  = '0;
        step(2);
        check("rst_out", 64'(pad_out), 64'(RstVal));
        check("rst_rise", 64'(rise), 64'd0);
        check("rst_fall", 64'(fall), 64'd0);

        // Reset release with pad 32 reset high but driven low.
        rst_n = 1'b1;
        step(2);
        check("p32_hold", 64'(pad_out[32]), 64'd1);
        step(1);
        check("p32_low", 64'(pad_out[32]), 64'd0);
        check("p32_fall", 64'(fall[32]), 64'd1);
        check("p32_norise", 64'(rise), 64'd0);
        step(1);
        check("p32_fall_end", 64'(fall[32]), 64'd0);

        // Pad 0, filter off: 3-clock latency.
        pad_in[0] = 1'b1;
        step(2);
        check("p0_early", 64'(pad_out[0]), 64'd0);
        step(1);
        check("p0_out", 64'(pad_out[0]), 64'd1);
        check("p0_rise", 64'(rise[0]), 64'd1);
        step(1);
        check("p0_rise_end", 64'(rise[0]), 64'd0);

        // Pad 5, T=4: 4-cycle glitch suppressed.
        filt_en[5] = 1'b1;
        thresh     = 4'd4;
        step(3);
        seen = 0;
        pad_in[5] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) pad_in[5] = 1'b0;
            step(1);
            if (pad_out[5] || rise[5] || fall[5]) seen++;
        end
        check("p5_glitch", 64'(seen), 64'd0);

        pad_in[5] = 1'b1;
        step(7);
        check("p5_early", 64'(pad_out[5]), 64'd0);
        step(1);
        check("p5_out", 64'(pad_out[5]), 64'd1);
        check("p5_rise", 64'(rise[5]), 64'd1);
        step(1);
        check("p5_rise_end", 64'(rise[5]), 64'd0);

        // T=15 bounce: high 3, low 1, then high.
        thresh    = 4'd15;
        pad_in[5] = 1'b0;
        step(25);
        check("bnc_pre", 64'(pad_out[5]), 64'd0);
        rise_cnt = 0;
        fall_cnt = 0;
        rise_at  = -1;
        for (int i = 0; i < 30; i++) begin
            pad_in[5] = (i == 3) ? 1'b0 : 1'b1;
            step(1);
            if (rise[5]) begin
                rise_cnt++;
                if (rise_at < 0) rise_at = i;
            end
            if (fall[5]) fall_cnt++;
        end
        check("bnc_rises", 64'(rise_cnt), 64'd1);
        check("bnc_falls", 64'(fall_cnt), 64'd0);
        check("bnc_when", 64'(rise_at), 64'd22);
        check("bnc_out", 64'(pad_out[5]), 64'd1);

        // Threshold lowered mid-count (cnt_q=8).
        pad_in[5] = 1'b0;
        step(11);
        check("thr_hold", 64'(pad_out[5]), 64'd1);
        thresh = 4'd3;
        step(1);
        check("thr_out", 64'(pad_out[5]), 64'd0);
        check("thr_fall", 64'(fall[5]), 64'd1);

        // Filter disabled mid-count.
        thresh    = 4'd15;
        pad_in[5] = 1'b1;
        step(11);
        check("dis_hold", 64'(pad_out[5]), 64'd0);
        filt_en[5] = 1'b0;
        step(1);
        check("dis_out", 64'(pad_out[5]), 64'd1);
        check("dis_rise", 64'(rise[5]), 64'd1);

        // Asynchronous reset mid-count with inputs moving.
        filt_en[5] = 1'b1;
        pad_in[5]  = 1'b0;
        pad_in[0]  = 1'b0;
        step(5);
        pad_in[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", 64'(pad_out), 64'(RstVal));
        check("arst_rise", 64'(rise), 64'd0);
        check("arst_fall", 64'(fall), 64'd0);
        pad_in = RstVal;
        #10;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ((rise != '0) || (fall != '0) || (pad_out != RstVal)) seen++;
        end
        check("arst_quiet", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
